// File: rtl/aes_avalon_master.sv
`default_nettype none
// ============================================================================
// Module   : aes_avalon_master
// Brief    : Avalon-MM initiator that loads key/ciphertext into the AES core,
//            polls for completion and reads back the decrypted message.
// Revision : 1.0 - initial release
// ============================================================================
module aes_avalon_master #(
  parameter int TIMEOUT_POLLS = 1023
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [127:0] KEY,
  input  logic [127:0] MSG_ENC,
  output logic [127:0] MSG_DEC,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR,
  output logic         AVL_READ,
  output logic         AVL_WRITE,
  output logic         AVL_CS,
  output logic [3:0]   AVL_BYTE_EN,
  output logic [3:0]   AVL_ADDR,
  output logic [31:0]  AVL_WRITEDATA,
  input  logic [31:0]  AVL_READDATA
);

  localparam int c_PW = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(TIMEOUT_POLLS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_SETUP   = 3'd1,
    S_WR_STROBE  = 3'd2,
    S_POLL       = 3'd3,
    S_READ       = 3'd4,
    S_CLR_SETUP  = 3'd5,
    S_CLR_STROBE = 3'd6,
    S_FINISH     = 3'd7
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [127:0]      r_key;
  logic [127:0]      r_msg_enc;
  logic [127:0]      r_msg_dec;
  logic              r_err;
  logic [3:0]        r_idx;
  logic [c_PW-1:0]   r_poll_cnt;

  logic              w_wr_last;
  logic              w_poll_last;
  logic [31:0]       w_wr_word;

  assign w_wr_last   = (r_idx == 4'd8);
  assign w_poll_last = (r_poll_cnt == c_POLL_LAST);
  // Index 0 selects the most significant word of the key/ciphertext.
  assign w_wr_word   = r_idx[2] ? r_msg_enc[{~r_idx[1:0], 5'd0} +: 32]
                                : r_key[{~r_idx[1:0], 5'd0} +: 32];

  assign MSG_DEC = r_msg_dec;
  assign ERR     = r_err;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    BUSY          = 1'b0;
    DONE          = 1'b0;
    AVL_READ      = 1'b0;
    AVL_WRITE     = 1'b0;
    AVL_CS        = 1'b0;
    AVL_BYTE_EN   = 4'h0;
    AVL_ADDR      = 4'h0;
    AVL_WRITEDATA = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (START) w_state_next = S_WR_SETUP;
      end
      S_WR_SETUP, S_WR_STROBE: begin
        BUSY          = 1'b1;
        AVL_BYTE_EN   = 4'hF;
        AVL_ADDR      = w_wr_last ? 4'd14 : r_idx;
        AVL_WRITEDATA = w_wr_last ? 32'h1 : w_wr_word;
        if (r_state == S_WR_SETUP) begin
          w_state_next = S_WR_STROBE;
        end else begin
          AVL_WRITE    = 1'b1;
          AVL_CS       = 1'b1;
          w_state_next = w_wr_last ? S_POLL : S_WR_SETUP;
        end
      end
      S_POLL: begin
        BUSY        = 1'b1;
        AVL_BYTE_EN = 4'hF;
        AVL_READ    = 1'b1;
        AVL_CS      = 1'b1;
        AVL_ADDR    = 4'd15;
        if (AVL_READDATA[0]) w_state_next = S_READ;
        else if (w_poll_last) w_state_next = S_CLR_SETUP;
      end
      S_READ: begin
        BUSY        = 1'b1;
        AVL_BYTE_EN = 4'hF;
        AVL_READ    = 1'b1;
        AVL_CS      = 1'b1;
        AVL_ADDR    = {2'b10, r_idx[1:0]};
        if (r_idx[1:0] == 2'd3) w_state_next = S_CLR_SETUP;
      end
      // Start (14) is cleared before done (15) so the core cannot re-raise done.
      S_CLR_SETUP, S_CLR_STROBE: begin
        BUSY        = 1'b1;
        AVL_BYTE_EN = 4'hF;
        AVL_ADDR    = {3'b111, r_idx[0]};
        if (r_state == S_CLR_SETUP) begin
          w_state_next = S_CLR_STROBE;
        end else begin
          AVL_WRITE    = 1'b1;
          AVL_CS       = 1'b1;
          w_state_next = r_idx[0] ? S_FINISH : S_CLR_SETUP;
        end
      end
      S_FINISH: begin
        DONE         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_key      <= '0;
      r_msg_enc  <= '0;
      r_msg_dec  <= '0;
      r_err      <= 1'b0;
      r_idx      <= 4'd0;
      r_poll_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_key     <= KEY;
            r_msg_enc <= MSG_ENC;
            r_err     <= 1'b0;
            r_idx     <= 4'd0;
          end
        end
        S_WR_STROBE: begin
          if (w_wr_last) begin
            r_idx      <= 4'd0;
            r_poll_cnt <= '0;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        S_POLL: begin
          if (AVL_READDATA[0]) begin
            r_idx <= 4'd0;
          end else if (w_poll_last) begin
            r_err <= 1'b1;
            r_idx <= 4'd0;
          end else begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
          end
        end
        S_READ: begin
          r_msg_dec[{r_idx[1:0], 5'd0} +: 32] <= AVL_READDATA;
          r_idx <= (r_idx[1:0] == 2'd3) ? 4'd0 : r_idx + 4'd1;
        end
        S_CLR_STROBE: begin
          r_idx <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_avalon_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_avalon_master
// Brief    : Self-checking bench with a register-file slave and an
//            operation-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_avalon_master;

  localparam int c_TO = 16;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [127:0] KEY = '0;
  logic [127:0] MSG_ENC = '0;
  logic [127:0] MSG_DEC;
  logic         BUSY, DONE, ERR, AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]   AVL_BYTE_EN, AVL_ADDR;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA;

  always #5 CLK = ~CLK;

  aes_avalon_master #(.TIMEOUT_POLLS(c_TO)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .KEY(KEY), .MSG_ENC(MSG_ENC),
    .MSG_DEC(MSG_DEC), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA)
  );

  // Slave register file: done and plaintext appear cfg_delay edges after start is set.
  logic [31:0]  slv_regs [16];
  int           slv_cnt = 0;
  int           cfg_delay = 0;
  bit           cfg_never = 1'b0;
  logic [127:0] cfg_pt = '0;

  assign AVL_READDATA = slv_regs[AVL_ADDR];

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) slv_regs[i] <= 32'h0;
      slv_cnt <= 0;
    end else begin
      if (AVL_WRITE && AVL_CS) slv_regs[AVL_ADDR] <= AVL_WRITEDATA;
      if (AVL_WRITE && AVL_CS && AVL_ADDR == 4'd14 && AVL_WRITEDATA[0] && !cfg_never) begin
        if (cfg_delay == 0) begin
          slv_regs[15] <= 32'h1;
          for (int i = 0; i < 4; i++) slv_regs[8+i] <= cfg_pt[32*i +: 32];
        end else begin
          slv_cnt <= cfg_delay;
        end
      end else if (slv_cnt != 0) begin
        slv_cnt <= slv_cnt - 1;
        if (slv_cnt == 1) begin
          slv_regs[15] <= 32'h1;
          for (int i = 0; i < 4; i++) slv_regs[8+i] <= cfg_pt[32*i +: 32];
        end
      end
    end
  end

  typedef struct packed { logic [3:0] a; logic [31:0] d; } wr_t;

  wr_t        wr_q [$];
  logic [3:0] rd_q [$];
  int         gcyc = 0, cyc = 0, done_cyc = 0, proto_err = 0;
  int         op_count = 0, op_starts = 0, last_done_g = 0, start_gap = 0;
  bit         in_op = 1'b0, prev_wr = 1'b0;
  logic [3:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic       w_bad;

  assign w_bad = (AVL_READ && AVL_WRITE)
              || (AVL_CS !== (AVL_READ | AVL_WRITE))
              || (AVL_BYTE_EN !== (BUSY ? 4'hF : 4'h0))
              || (!BUSY && !DONE)
              || (AVL_WRITE && AVL_CS && (prev_wr || AVL_ADDR !== prev_addr
                                          || AVL_WRITEDATA !== prev_data));

  always @(negedge CLK) begin
    gcyc      <= gcyc + 1;
    prev_wr   <= AVL_WRITE;
    prev_addr <= AVL_ADDR;
    prev_data <= AVL_WRITEDATA;
    if (RESET) begin
      in_op <= 1'b0;
    end else if (BUSY && !in_op) begin
      in_op     <= 1'b1;
      cyc       <= 0;
      wr_q.delete();
      rd_q.delete();
      proto_err <= (AVL_BYTE_EN !== 4'hF || AVL_CS || AVL_READ || AVL_WRITE) ? 1 : 0;
      op_starts <= op_starts + 1;
      start_gap <= gcyc - last_done_g;
    end else if (in_op) begin
      cyc <= cyc + 1;
      if (AVL_WRITE && AVL_CS) wr_q.push_back(wr_t'({AVL_ADDR, AVL_WRITEDATA}));
      if (AVL_READ && AVL_CS) rd_q.push_back(AVL_ADDR);
      if (w_bad) proto_err <= proto_err + 1;
      if (DONE) begin
        done_cyc    <= cyc + 1;
        in_op       <= 1'b0;
        op_count    <= op_count + 1;
        last_done_g <= gcyc;
      end
    end
  end

  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_dec = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [127:0] k, input logic [127:0] c,
                        input logic [127:0] pt, input int d, input bit never);
    cfg_pt = pt; cfg_delay = d; cfg_never = never;
    @(posedge CLK); #1;
    KEY = k; MSG_ENC = c; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int b = 0;
    while (op_count == n0 && b < 300) begin @(posedge CLK); b++; end
    #1;
    chk("wait_done", 128'(op_count != n0), 128'(1));
  endtask

  // Reference model of one whole operation, built from the slave map and cycle budget.
  task automatic check_op(input string tag, input logic [127:0] k, input logic [127:0] c,
                          input logic [127:0] pt, input int d, input bit never);
    bit   to = never || (d + 1 > c_TO);
    int   p  = to ? c_TO : d + 1;
    int   npoll = 0, mism = 0;
    wr_t  exp_w [$];
    logic [3:0] exp_r [$];
    for (int i = 0; i < 4; i++) exp_w.push_back(wr_t'({4'(i), k[127-32*i -: 32]}));
    for (int i = 0; i < 4; i++) exp_w.push_back(wr_t'({4'(4+i), c[127-32*i -: 32]}));
    exp_w.push_back(wr_t'({4'd14, 32'h1}));
    exp_w.push_back(wr_t'({4'd14, 32'h0}));
    exp_w.push_back(wr_t'({4'd15, 32'h0}));
    for (int i = 0; i < p; i++) exp_r.push_back(4'd15);
    if (!to) for (int i = 0; i < 4; i++) exp_r.push_back(4'(8+i));
    if (!to) exp_dec = pt;

    chk({tag, " done_cycle"}, 128'(done_cyc), 128'(to ? 22 + p : 26 + p));
    chk({tag, " err"}, 128'(ERR), 128'(to));
    chk({tag, " msg_dec"}, MSG_DEC, exp_dec);
    chk({tag, " n_writes"}, 128'(wr_q.size()), 128'(11));
    for (int i = 0; i < 11; i++)
      chk($sformatf("%s write%0d", tag, i), 128'(wr_q[i]), 128'(exp_w[i]));
    foreach (rd_q[i]) if (rd_q[i] == 4'd15) npoll++;
    chk({tag, " n_polls"}, 128'(npoll), 128'(p));
    chk({tag, " n_reads"}, 128'(rd_q.size()), 128'(exp_r.size()));
    foreach (exp_r[i]) if (rd_q[i] !== exp_r[i]) mism++;
    chk({tag, " read_order"}, 128'(mism), 128'(0));
    chk({tag, " protocol"}, 128'(proto_err), 128'(0));
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s slave_reg%0d", tag, i), 128'(slv_regs[i]), 128'(exp_w[i].d));
    chk({tag, " slave_start"}, 128'(slv_regs[14]), 128'(0));
    chk({tag, " slave_done"}, 128'(slv_regs[15]), 128'(0));
  endtask

  task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] c,
                        input logic [127:0] pt, input int d, input bit never);
    int n0 = op_count;
    launch(k, c, pt, d, never);
    wait_done(n0);
    check_op(tag, k, c, pt, d, never);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k1, k2, c1, p1;
    int n0, s0, b;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset msg_dec", MSG_DEC, 128'(0));
    chk("reset ctl", 128'({BUSY, DONE, ERR, AVL_READ, AVL_WRITE, AVL_CS,
                           AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA}), 128'(0));
    RESET = 1'b0;

    run_op("fips", 128'h000102030405060708090a0b0c0d0e0f,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           128'h00112233445566778899aabbccddeeff, 12, 1'b0);
    run_op("first_poll", rnd128(), rnd128(), rnd128(), 0, 1'b0);
    run_op("last_poll", rnd128(), rnd128(), rnd128(), c_TO - 1, 1'b0);
    run_op("late_done", rnd128(), rnd128(), rnd128(), c_TO, 1'b0);
    run_op("never_done", rnd128(), rnd128(), rnd128(), 0, 1'b1);
    for (int i = 0; i < 3; i++)
      run_op($sformatf("rand%0d", i), rnd128(), rnd128(), rnd128(),
             int'($urandom_range(0, 10)), 1'b0);

    // START held through an operation: one op, then a second with the new key.
    k1 = rnd128(); k2 = rnd128(); c1 = rnd128(); p1 = rnd128();
    n0 = op_count; s0 = op_starts;
    cfg_pt = p1; cfg_delay = 3; cfg_never = 1'b0;
    @(posedge CLK); #1;
    KEY = k1; MSG_ENC = c1; START = 1'b1;
    b = 0;
    while (op_starts == s0 && b < 20) begin @(posedge CLK); b++; end
    #1;
    chk("held started", 128'(op_starts != s0), 128'(1));
    KEY = k2;
    wait_done(n0);
    check_op("held1", k1, c1, p1, 3, 1'b0);
    n0 = op_count;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(n0);
    check_op("held2", k2, c1, p1, 3, 1'b0);
    chk("held gap", 128'(start_gap), 128'(2));
    chk("held op_starts", 128'(op_starts - s0), 128'(2));

    // Reset while polling.
    launch(rnd128(), rnd128(), rnd128(), 0, 1'b1);
    b = 0;
    while (rd_q.size() < 3 && b < 60) begin @(posedge CLK); b++; end
    #1;
    chk("reached poll", 128'(rd_q.size() >= 3), 128'(1));
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("poll_reset msg_dec", MSG_DEC, 128'(0));
    chk("poll_reset ctl", 128'({BUSY, DONE, ERR, AVL_READ, AVL_WRITE, AVL_CS,
                                AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA}), 128'(0));
    RESET = 1'b0;
    exp_dec = '0;
    run_op("after_reset", rnd128(), rnd128(), rnd128(), 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
